// File: rtl/cover_toggle_pkg.sv
// Shared definitions for the toggle-coverage detector: count-width helper,
// width limit and the coverage-mode enumeration used for reporting.
package cover_toggle_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    DIR_BOTH,
    DIR_SINGLE
  } cover_mode_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cover_toggle_bit.sv
// One monitored bit: edge history, sticky coverage and newly-covered strobe.
// Macro COVER_TOGGLE_SINGLE_DIR_EN lets a single edge direction complete coverage.
module cover_toggle_bit
  import cover_toggle_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic sig,
  input  logic detect,
  input  logic clear,
  output logic newly,
  output logic covered
);

  logic prev;
  logic rise_seen;
  logic fall_seen;
  logic rise_next;
  logic fall_next;
  logic complete;

  always_comb begin
    rise_next = rise_seen | (detect & sig & ~prev);
    fall_next = fall_seen | (detect & ~sig & prev);
`ifdef COVER_TOGGLE_SINGLE_DIR_EN
    complete  = rise_next | fall_next;
`else
    complete  = rise_next & fall_next;
`endif
    newly     = complete & ~covered;
  end

  // prev tracks sig unconditionally so re-enabling never sees a stale edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev      <= 1'b0;
      rise_seen <= 1'b0;
      fall_seen <= 1'b0;
      covered   <= 1'b0;
    end else begin
      prev <= sig;
      if (clear) begin
        rise_seen <= 1'b0;
        fall_seen <= 1'b0;
        covered   <= 1'b0;
      end else begin
        rise_seen <= rise_next;
        fall_seen <= fall_next;
        covered   <= covered | newly;
      end
    end
  end

endmodule

// File: rtl/cover_toggle_detector.sv
// Toggle-coverage detector: one-shot valid pulse per bit on first full toggle,
// plus sticky bitmap and popcount. Macro COVER_TOGGLE_SINGLE_DIR_EN: either edge covers.
module cover_toggle_detector
  import cover_toggle_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] valid,
  output logic [WIDTH-1:0] covered,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  logic             primed;
  logic             detect;
  logic [WIDTH-1:0] newly;
  logic [WIDTH-1:0] covered_next;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // the first sample after reset/clear only loads prev, it never counts as an edge
  assign detect = primed & enable;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cover_toggle_bit u_bit (
      .clock   (clock),
      .reset   (reset),
      .sig     (sig[i]),
      .detect  (detect),
      .clear   (clear),
      .newly   (newly[i]),
      .covered (covered[i])
    );
  end

  assign covered_next = clear ? '0 : (covered | newly);

  // count and all_covered are derived from the same next value as covered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      primed        <= 1'b0;
      valid         <= '0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else begin
      primed        <= ~clear;
      valid         <= clear ? '0 : newly;
      covered_count <= popcount(covered_next);
      all_covered   <= &covered_next;
    end
  end

endmodule

// File: tb/tb_cover_toggle_detector.sv
// Scenario bench for cover_toggle_detector (WIDTH=5) with a queue scoreboard;
// expectations follow COVER_TOGGLE_SINGLE_DIR_EN when it is defined.
module tb_cover_toggle_detector;
  import cover_toggle_pkg::*;

`ifdef COVER_TOGGLE_SINGLE_DIR_EN
  localparam bit SINGLE = 1'b1;
`else
  localparam bit SINGLE = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] v;
    logic [4:0] c;
    logic [2:0] n;
    logic       a;
  } obs_t;

  logic       clock;
  logic       reset;
  logic [4:0] sig;
  logic       enable;
  logic       clear;
  logic [4:0] valid;
  logic [4:0] covered;
  logic [2:0] covered_count;
  logic       all_covered;

  obs_t exp_q[$];
  int   vectors;
  int   miscompares;

  cover_toggle_detector #(.WIDTH(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .sig           (sig),
    .enable        (enable),
    .clear         (clear),
    .valid         (valid),
    .covered       (covered),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic [4:0] v, input logic [4:0] c,
                              input logic [2:0] n, input logic a);
    return '{v, c, n, a};
  endfunction

  task automatic step(input logic [4:0] s, input logic en, input logic cl);
    sig = s; enable = en; clear = cl;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [4:0] s);
    reset = 1'b0; sig = s; enable = 1'b1; clear = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    reset = 1'b0; sig = 5'b10101; enable = 1'b1; clear = 1'b0;
    #12;
    exp_q.push_back(mk(5'b0, 5'b0, 3'd0, 1'b0));
    got = {valid, covered, covered_count, all_covered};
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_hold: got %b/%b/%0d/%b want %b/%b/%0d/%b",
               got.v, got.c, got.n, got.a, want.v, want.c, want.n, want.a);
    end
    @(posedge clock); #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk(5'b0, 5'b0, 3'd0, 1'b0));
      step(5'b10101, 1'b1, 1'b0);
      got = {valid, covered, covered_count, all_covered};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_static step %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                 got.v, got.c, got.n, got.a, want.v, want.c, want.n, want.a);
      end
    end
  endtask

  task automatic test_single_bit();
    logic [4:0] s [8] = '{5'd0, 5'd1, 5'd0, 5'd0, 5'd1, 5'd0, 5'd1, 5'd0};
    obs_t e [8];
    obs_t got, want;
    e = '{mk(5'd0, 5'd0, 3'd0, 1'b0),
          mk(SINGLE ? 5'd1 : 5'd0, SINGLE ? 5'd1 : 5'd0, SINGLE ? 3'd1 : 3'd0, 1'b0),
          mk(SINGLE ? 5'd0 : 5'd1, 5'd1, 3'd1, 1'b0),
          mk(5'd0, 5'd1, 3'd1, 1'b0), mk(5'd0, 5'd1, 3'd1, 1'b0),
          mk(5'd0, 5'd1, 3'd1, 1'b0), mk(5'd0, 5'd1, 3'd1, 1'b0),
          mk(5'd0, 5'd1, 3'd1, 1'b0)};
    do_reset(5'd0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(e[i]);
      step(s[i], 1'b1, 1'b0);
      got = {valid, covered, covered_count, all_covered};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL single_bit step %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                 got.v, got.c, got.n, got.a, want.v, want.c, want.n, want.a);
      end
    end
  endtask

  task automatic test_all_bits();
    logic [4:0] s [4] = '{5'h00, 5'h1F, 5'h00, 5'h00};
    obs_t e [4];
    obs_t got, want;
    e = '{mk(5'd0, 5'd0, 3'd0, 1'b0),
          mk(SINGLE ? 5'h1F : 5'h0, SINGLE ? 5'h1F : 5'h0, SINGLE ? 3'd5 : 3'd0, SINGLE),
          mk(SINGLE ? 5'h00 : 5'h1F, 5'h1F, 3'd5, 1'b1),
          mk(5'h00, 5'h1F, 3'd5, 1'b1)};
    do_reset(5'd0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e[i]);
      step(s[i], 1'b1, 1'b0);
      got = {valid, covered, covered_count, all_covered};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL all_bits step %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                 got.v, got.c, got.n, got.a, want.v, want.c, want.n, want.a);
      end
    end
  endtask

  task automatic test_enable();
    logic [4:0] s  [7] = '{5'd0, 5'd4, 5'd0, 5'd4, 5'd4, 5'd0, 5'd4};
    logic       en [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    obs_t e [7];
    obs_t got, want;
    e = '{mk(5'd0, 5'd0, 3'd0, 1'b0), mk(5'd0, 5'd0, 3'd0, 1'b0),
          mk(5'd0, 5'd0, 3'd0, 1'b0), mk(5'd0, 5'd0, 3'd0, 1'b0),
          mk(5'd0, 5'd0, 3'd0, 1'b0),
          mk(SINGLE ? 5'd4 : 5'd0, SINGLE ? 5'd4 : 5'd0, SINGLE ? 3'd1 : 3'd0, 1'b0),
          mk(SINGLE ? 5'd0 : 5'd4, 5'd4, 3'd1, 1'b0)};
    do_reset(5'd0);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(e[i]);
      step(s[i], en[i], 1'b0);
      got = {valid, covered, covered_count, all_covered};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL enable_gate step %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                 got.v, got.c, got.n, got.a, want.v, want.c, want.n, want.a);
      end
    end
  endtask

  task automatic test_clear();
    logic [4:0] s  [6] = '{5'd0, 5'd8, 5'd0, 5'd8, 5'd0, 5'd8};
    logic       cl [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    obs_t e [6];
    obs_t got, want;
    e = '{mk(5'd0, 5'd0, 3'd0, 1'b0),
          mk(SINGLE ? 5'd8 : 5'd0, SINGLE ? 5'd8 : 5'd0, SINGLE ? 3'd1 : 3'd0, 1'b0),
          mk(5'd0, 5'd0, 3'd0, 1'b0),
          mk(5'd0, 5'd0, 3'd0, 1'b0),
          mk(SINGLE ? 5'd8 : 5'd0, SINGLE ? 5'd8 : 5'd0, SINGLE ? 3'd1 : 3'd0, 1'b0),
          mk(SINGLE ? 5'd0 : 5'd8, 5'd8, 3'd1, 1'b0)};
    do_reset(5'd0);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(e[i]);
      step(s[i], 1'b1, cl[i]);
      got = {valid, covered, covered_count, all_covered};
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL clear step %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i,
                 got.v, got.c, got.n, got.a, want.v, want.c, want.n, want.a);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [4:0] s [3] = '{5'd0, 5'd2, 5'd0};
    obs_t e [3];
    obs_t got, want;
    e = '{mk(5'd0, 5'd0, 3'd0, 1'b0),
          mk(SINGLE ? 5'd2 : 5'd0, SINGLE ? 5'd2 : 5'd0, SINGLE ? 3'd1 : 3'd0, 1'b0),
          mk(SINGLE ? 5'd0 : 5'd2, 5'd2, 3'd1, 1'b0)};
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(5'd0);
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(e[i]);
        step(s[i], 1'b1, 1'b0);
        got = {valid, covered, covered_count, all_covered};
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL mid_reset pass %0d step %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b",
                   pass, i, got.v, got.c, got.n, got.a, want.v, want.c, want.n, want.a);
        end
      end
      if (pass == 0) begin
        reset = 1'b0;
        #1;
        exp_q.push_back(mk(5'd0, 5'd0, 3'd0, 1'b0));
        got = {valid, covered, covered_count, all_covered};
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL async_drop: got %b/%b/%0d/%b want %b/%b/%0d/%b",
                   got.v, got.c, got.n, got.a, want.v, want.c, want.n, want.a);
        end
      end
    end
  endtask

  initial begin
    cover_mode_e mode;
    vectors = 0;
    miscompares = 0;
    reset = 1'b0; sig = '0; enable = 1'b0; clear = 1'b0;
    mode = SINGLE ? DIR_SINGLE : DIR_BOTH;
    $display("coverage mode %s", mode.name());
    test_reset();
    test_single_bit();
    test_all_bits();
    test_enable();
    test_clear();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
